// File: rtl/wb_arbiter.sv
// Write-back arbiter: picks one of ALU/LSU/MUL-DIV per cycle by fixed priority with
// starvation promotion, and registers the winner onto the register file write port.
module wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           req_valid,
    output logic [2:0]           req_ready,
    input  logic [2:0][4:0]      req_rd_addr,
    input  logic [2:0][XLEN-1:0] req_rd_data,
    output logic                 rd_wr_en,
    output logic [4:0]           rd_addr,
    output logic [XLEN-1:0]      rd_data
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [2:0][3:0]  wait_cnt;
    logic [2:0]       starved;
    logic [2:0]       candidates;
    logic             xfer;
    logic [4:0]       sel_addr;
    logic [XLEN-1:0]  sel_data;

    // Starved requesters form their own priority class ahead of everyone else;
    // within a class the lowest index wins (isolate the lowest set bit).
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            starved[i] = req_valid[i] && (wait_cnt[i] == LIMIT);
        end
        candidates = (starved != 3'b000) ? starved : req_valid;
        req_ready  = rst ? 3'b000 : (candidates & (~candidates + 3'd1));
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < 3; i++) begin
            if (req_ready[i]) begin
                sel_addr = req_rd_addr[i];
                sel_data = req_rd_data[i];
            end
        end
        xfer = (req_ready != 3'b000);
    end

    // A counter restarts whenever its request goes away (transfer or flush).
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst || !req_valid[i] || req_ready[i]) begin
                wait_cnt[i] <= 4'd0;
            end else if (wait_cnt[i] != LIMIT) begin
                wait_cnt[i] <= wait_cnt[i] + 4'd1;
            end
        end
    end

    // x0 writes are consumed but never reach the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_wr_en <= 1'b0;
            rd_addr  <= 5'd0;
            rd_data  <= '0;
        end else begin
            rd_wr_en <= xfer && (sel_addr != 5'd0);
            if (xfer) begin
                rd_addr <= sel_addr;
                rd_data <= sel_data;
            end
        end
    end

endmodule
